collision_detector: RTL

Frame-synchronous consumer of the car position buses driven by the per-lane car controllers. Once per video frame it snapshots the frog box and all car boxes, then scans the cars one per clock with rectangle-overlap tests. On the first overlap it emits a hit pulse, decrements the lives counter, and enters a grace period or game-over. It sits between the car and frog controllers and the top-level game FSM and scoring/display logic.

---
 rtl/frogger_pkg.sv | 30 +++
 rtl/collision_detector_if.sv | 29 ++
 rtl/collision_detector_rect_overlap.sv | 26 ++
 rtl/collision_detector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared frogger types and constants: state encoding, coordinate widths, default box sizes.
package frogger_pkg;

  localparam int unsigned c_COORD_W     = 10;
  localparam int unsigned c_SUM_W       = c_COORD_W + 1;
  localparam int unsigned c_GAME_WIDTH  = 640;
  localparam int unsigned c_GAME_HEIGHT = 480;

  localparam int unsigned c_DEF_CAR_WIDTH  = 64;
  localparam int unsigned c_DEF_CAR_HEIGHT = 32;
  localparam int unsigned c_DEF_FROG_SIZE  = 32;

  localparam int unsigned c_HIT_IDX_W = 4;
  localparam int unsigned c_LIVES_W   = 3;
  localparam int unsigned c_GRACE_W   = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HIT,
    ST_GRACE,
    ST_OVER
  } cd_state_e;

  typedef struct packed {
    logic [c_COORD_W-1:0] x;
    logic [c_COORD_W-1:0] y;
  } box_pos_t;

endpackage

// File: rtl/collision_detector_if.sv
// Bus bundle between the car/frog controllers, the collision detector and the game FSM.
interface collision_detector_if #(
  parameter int unsigned c_NUM_CARS = 8
);
  import frogger_pkg::*;

  logic                             i_Game_Active;
  logic                             i_Frame_Start;
  logic [c_COORD_W-1:0]             i_Frog_X;
  logic [c_COORD_W-1:0]             i_Frog_Y;
  logic [c_COORD_W*c_NUM_CARS-1:0]  i_Cars_X;
  logic [c_COORD_W*c_NUM_CARS-1:0]  i_Cars_Y;
  logic                             o_Hit;
  logic [c_HIT_IDX_W-1:0]           o_Hit_Index;
  logic [c_LIVES_W-1:0]             o_Lives;
  logic                             o_Game_Over;
  logic                             o_Busy;

  modport master (
    output i_Game_Active, i_Frame_Start, i_Frog_X, i_Frog_Y, i_Cars_X, i_Cars_Y,
    input  o_Hit, o_Hit_Index, o_Lives, o_Game_Over, o_Busy
  );

  modport slave (
    input  i_Game_Active, i_Frame_Start, i_Frog_X, i_Frog_Y, i_Cars_X, i_Cars_Y,
    output o_Hit, o_Hit_Index, o_Lives, o_Game_Over, o_Busy
  );

endinterface

// File: rtl/collision_detector_rect_overlap.sv
// Combinational box-overlap test; 11-bit sums so boxes hanging off the right/bottom never wrap.
module rect_overlap
  import frogger_pkg::*;
#(
  parameter int unsigned c_A_W = c_DEF_FROG_SIZE,
  parameter int unsigned c_A_H = c_DEF_FROG_SIZE,
  parameter int unsigned c_B_W = c_DEF_CAR_WIDTH,
  parameter int unsigned c_B_H = c_DEF_CAR_HEIGHT
) (
  input  box_pos_t a_pos_i,
  input  box_pos_t b_pos_i,
  output logic     overlap_c_o
);

  logic [c_SUM_W-1:0] ax, ay, bx, by;

  assign ax = c_SUM_W'(a_pos_i.x);
  assign ay = c_SUM_W'(a_pos_i.y);
  assign bx = c_SUM_W'(b_pos_i.x);
  assign by = c_SUM_W'(b_pos_i.y);

  // Strict compares: boxes that only share an edge are not overlapping.
  assign overlap_c_o = (ax < bx + c_SUM_W'(c_B_W)) && (bx < ax + c_SUM_W'(c_A_W)) &&
                       (ay < by + c_SUM_W'(c_B_H)) && (by < ay + c_SUM_W'(c_A_H));

endmodule

// File: rtl/collision_detector.sv
// Per-frame frog/car collision scan with lives tracking.
// Optional feature macro COLLISION_GRACE_EN adds the post-hit GRACE invulnerability counter.
module collision_detector
  import frogger_pkg::*;
#(
  parameter int unsigned c_NUM_CARS     = 8,
  parameter int unsigned c_CAR_WIDTH    = c_DEF_CAR_WIDTH,
  parameter int unsigned c_CAR_HEIGHT   = c_DEF_CAR_HEIGHT,
  parameter int unsigned c_FROG_SIZE    = c_DEF_FROG_SIZE,
  parameter int unsigned c_LIVES        = 3,
  parameter int unsigned c_GRACE_CYCLES = 25000000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  collision_detector_if.slave   cd_if
);

  localparam int unsigned c_IDX_W = (c_NUM_CARS > 1) ? $clog2(c_NUM_CARS) : 1;

  if (c_NUM_CARS < 1 || c_NUM_CARS > (1 << c_HIT_IDX_W)) begin : g_chk_cars
    $error("collision_detector: c_NUM_CARS out of range");
  end
  if (c_LIVES < 1 || c_LIVES > ((1 << c_LIVES_W) - 1)) begin : g_chk_lives
    $error("collision_detector: c_LIVES out of range");
  end
  if (c_GRACE_CYCLES < 1 || c_GRACE_CYCLES > (1 << c_GRACE_W)) begin : g_chk_grace
    $error("collision_detector: c_GRACE_CYCLES out of range");
  end
  if ((c_GAME_WIDTH + c_CAR_WIDTH >= (1 << c_SUM_W)) ||
      (c_GAME_HEIGHT + c_CAR_HEIGHT >= (1 << c_SUM_W))) begin : g_chk_sum
    $error("collision_detector: box extents overflow the overlap adder");
  end

  cd_state_e              state_q, state_d;
  logic [c_IDX_W-1:0]     idx_q, idx_d;
  box_pos_t               frog_q, frog_d;
  box_pos_t               cars_q [c_NUM_CARS];
  box_pos_t               cars_d [c_NUM_CARS];
  logic                   hit_q, hit_d;
  logic [c_HIT_IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic [c_LIVES_W-1:0]   lives_q, lives_d;
  logic                   over_q, over_d;
  logic                   busy_q, busy_d;
`ifdef COLLISION_GRACE_EN
  logic [c_GRACE_W-1:0]   grace_q, grace_d;
`endif

  box_pos_t car_sel_c;
  logic     overlap_c;

  assign car_sel_c = cars_q[idx_q];

  rect_overlap #(
    .c_A_W (c_FROG_SIZE),
    .c_A_H (c_FROG_SIZE),
    .c_B_W (c_CAR_WIDTH),
    .c_B_H (c_CAR_HEIGHT)
  ) u_overlap (
    .a_pos_i     (frog_q),
    .b_pos_i     (car_sel_c),
    .overlap_c_o (overlap_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frog_d    = frog_q;
    cars_d    = cars_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    lives_d   = lives_q;
    over_d    = over_q;
`ifdef COLLISION_GRACE_EN
    grace_d   = grace_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cd_if.i_Frame_Start) begin
          frog_d.x = cd_if.i_Frog_X;
          frog_d.y = cd_if.i_Frog_Y;
          for (int k = 0; k < int'(c_NUM_CARS); k++) begin
            cars_d[k].x = cd_if.i_Cars_X[k*int'(c_COORD_W) +: c_COORD_W];
            cars_d[k].y = cd_if.i_Cars_Y[k*int'(c_COORD_W) +: c_COORD_W];
          end
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (overlap_c) begin
          state_d   = ST_HIT;
          hit_d     = 1'b1;
          hit_idx_d = c_HIT_IDX_W'(idx_q);
          if (lives_q != '0) lives_d = lives_q - c_LIVES_W'(1);
          if (lives_q <= c_LIVES_W'(1)) over_d = 1'b1;
        end else if (idx_q == c_IDX_W'(c_NUM_CARS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + c_IDX_W'(1);
        end
      end
      ST_HIT: begin
        if (lives_q == '0) begin
          state_d = ST_OVER;
        end else begin
`ifdef COLLISION_GRACE_EN
          grace_d = c_GRACE_W'(c_GRACE_CYCLES - 1);
          state_d = ST_GRACE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_GRACE: begin
`ifdef COLLISION_GRACE_EN
        if (grace_q == '0) state_d = ST_IDLE;
        else               grace_d = grace_q - c_GRACE_W'(1);
`else
        state_d = ST_IDLE;
`endif
      end
      ST_OVER: ;
      default: state_d = ST_IDLE;
    endcase

    // Dropping Game_Active reloads the detector from any state.
    if (!cd_if.i_Game_Active) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      lives_d   = c_LIVES_W'(c_LIVES);
      over_d    = 1'b0;
`ifdef COLLISION_GRACE_EN
      grace_d   = '0;
`endif
    end

    busy_d = (state_d == ST_SCAN) || (state_d == ST_HIT) || (state_d == ST_GRACE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      frog_q    <= '0;
      for (int k = 0; k < int'(c_NUM_CARS); k++) cars_q[k] <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      lives_q   <= c_LIVES_W'(c_LIVES);
      over_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef COLLISION_GRACE_EN
      grace_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frog_q    <= frog_d;
      cars_q    <= cars_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      lives_q   <= lives_d;
      over_q    <= over_d;
      busy_q    <= busy_d;
`ifdef COLLISION_GRACE_EN
      grace_q   <= grace_d;
`endif
    end
  end

  assign cd_if.o_Hit       = hit_q;
  assign cd_if.o_Hit_Index = hit_idx_q;
  assign cd_if.o_Lives     = lives_q;
  assign cd_if.o_Game_Over = over_q;
  assign cd_if.o_Busy      = busy_q;

endmodule
